gate_sweep_ctrl: RTL

Self-checking sweep controller for the simple combinational gate circuits in the test suite. On `start` it sequences every input vector of an N-input gate DUT, waits a settle interval, compares the DUT output against a built-in golden model for the selected operation, and reports pass/fail, the error count and the first failing vector. It sits between the testbench and a gate DUT and replaces hand-written stimulus lists such as `a=0;b=0;#10;...`.

---
 rtl/gate_sweep_pkg.sv | 18 +
 rtl/gate_sweep_ctrl_golden.sv | 23 ++
 rtl/gate_sweep_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/gate_sweep_pkg.sv
// Shared types for the gate sweep controller and its golden model.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/gate_sweep_ctrl_golden.sv
// Combinational golden model for an N-input AND/OR/XOR/NAND gate.
module gate_golden
  import gate_sweep_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  op_e             op,
  input  logic [N_IN-1:0] vec,
  output logic            exp
);

  always_comb begin
    exp = 1'b0;
    case (op)
      OP_AND:  exp = &vec;
      OP_OR:   exp = |vec;
      OP_XOR:  exp = ^vec;
      OP_NAND: exp = ~&vec;
      default: exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweep controller: drives every input vector to a gate DUT and checks it against gate_golden.
// Optional stuck-output detection is built when GATE_SWEEP_STUCK_DETECT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start; results of the last sweep held
// SETTLE | stim held while the DUT output settles
// CHECK  | compare dut_out with golden, advance vector
// DONE   | one-cycle completion pulse, pass valid
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic            dut_out,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec,
`ifdef GATE_SWEEP_STUCK_DETECT_EN
  output logic            stuck0,
  output logic            stuck1,
`endif
  output logic            fail_seen
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST    = '1;
  localparam logic [N_IN:0]   ERR_MAX     = {1'b1, {N_IN{1'b0}}};

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_IN-1:0]   stim_q, stim_d;
  logic [N_IN-1:0]   ffv_q, ffv_d;
  logic [N_IN:0]     err_q, err_d;
  logic              pass_q, pass_d;
  logic              fs_q, fs_d;
  logic              golden;
  logic              mismatch;
`ifdef GATE_SWEEP_STUCK_DETECT_EN
  logic              all0_q, all0_d, all1_q, all1_d;
  logic              stuck0_q, stuck0_d, stuck1_q, stuck1_d;
`endif

  gate_golden #(.N_IN(N_IN)) u_golden (
    .op  (op_q),
    .vec (stim_q),
    .exp (golden)
  );

  // Case inequality so an X/Z DUT output is never mistaken for a match.
  assign mismatch = (dut_out !== golden);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    stim_d  = stim_q;
    ffv_d   = ffv_q;
    err_d   = err_q;
    pass_d  = pass_q;
    fs_d    = fs_q;
`ifdef GATE_SWEEP_STUCK_DETECT_EN
    all0_d   = all0_q;
    all1_d   = all1_q;
    stuck0_d = stuck0_q;
    stuck1_d = stuck1_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op_e'(op);
          err_d   = '0;
          ffv_d   = '0;
          fs_d    = 1'b0;
          pass_d  = 1'b0;
          stim_d  = '0;
          cnt_d   = SETTLE_LOAD;
          state_d = gate_sweep_pkg::SETTLE;
`ifdef GATE_SWEEP_STUCK_DETECT_EN
          all0_d   = 1'b1;
          all1_d   = 1'b1;
          stuck0_d = 1'b0;
          stuck1_d = 1'b0;
`endif
        end
      end
      gate_sweep_pkg::SETTLE: begin
        if (cnt_q == '0) state_d = CHECK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      CHECK: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) err_d = err_q + 1'b1;
          if (!fs_q) begin
            ffv_d = stim_q;
            fs_d  = 1'b1;
          end
        end
`ifdef GATE_SWEEP_STUCK_DETECT_EN
        if (dut_out !== 1'b0) all0_d = 1'b0;
        if (dut_out !== 1'b1) all1_d = 1'b0;
`endif
        if (stim_q == VEC_LAST) begin
          pass_d  = ~(fs_q | mismatch);
          state_d = DONE;
`ifdef GATE_SWEEP_STUCK_DETECT_EN
          stuck0_d = all0_q & (dut_out === 1'b0);
          stuck1_d = all1_q & (dut_out === 1'b1);
`endif
        end else begin
          stim_d  = stim_q + 1'b1;
          cnt_d   = SETTLE_LOAD;
          state_d = gate_sweep_pkg::SETTLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_AND;
      cnt_q   <= '0;
      stim_q  <= '0;
      ffv_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      fs_q    <= 1'b0;
`ifdef GATE_SWEEP_STUCK_DETECT_EN
      all0_q   <= 1'b0;
      all1_q   <= 1'b0;
      stuck0_q <= 1'b0;
      stuck1_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      ffv_q   <= ffv_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      fs_q    <= fs_d;
`ifdef GATE_SWEEP_STUCK_DETECT_EN
      all0_q   <= all0_d;
      all1_q   <= all1_d;
      stuck0_q <= stuck0_d;
      stuck1_q <= stuck1_d;
`endif
    end
  end

  assign stim           = stim_q;
  assign busy           = (state_q == gate_sweep_pkg::SETTLE) || (state_q == CHECK);
  assign done           = (state_q == DONE);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_vec = ffv_q;
  assign fail_seen      = fs_q;
`ifdef GATE_SWEEP_STUCK_DETECT_EN
  assign stuck0         = stuck0_q;
  assign stuck1         = stuck1_q;
`endif

endmodule
